coin_front_end: RTL

COIN_FRONT_END -- requirements
Module: coin_front_end

---
 rtl/vending_pkg.sv | 32 +++
 rtl/debounce_sync.sv | 59 +++++
 rtl/coin_front_end.sv | 98 +++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared vending constants: debounce defaults and coin priority
// Purpose: constants shared by the coin front end and the vending FSM.
//   DB_COUNT_DEFAULT / CNT_W_DEFAULT : debounce length (10 ms at 50 MHz) and counter width
//   coin_e                           : coin index; lower index has higher emission priority
//   pick_coin()                      : one-hot grant of the highest-priority requested coin
package vending_pkg;

  localparam int unsigned DB_COUNT_DEFAULT = 500000;
  localparam int unsigned CNT_W_DEFAULT    = 20;
  localparam int unsigned NUM_COINS        = 3;

  // Priority order is the index order: quarter > nickel > dime.
  typedef enum logic [1:0] {
    COIN_QUARTER = 2'd0,
    COIN_NICKEL  = 2'd1,
    COIN_DIME    = 2'd2
  } coin_e;

  function automatic logic [NUM_COINS-1:0] pick_coin(input logic [NUM_COINS-1:0] req);
    logic [NUM_COINS-1:0] grant;
    grant = '0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - 2-flop synchronizer followed by a counting debouncer
// Purpose: bring one raw asynchronous contact into the clk domain and filter bounce.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-high reset
//   raw    : raw asynchronous input
//   stable : debounced level, changes only after DB_COUNT consecutive mismatching samples
module debounce_sync
  import vending_pkg::*;
#(
  parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any sample agreeing with the current level restarts the count, so a bounce
  // before the count completes leaves stable untouched.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/coin_front_end.sv
// rtl/coin_front_end.sv - debounced coin/select inputs with prioritized one-pulse coin emission
// Purpose: debounce coin contacts and drink switches, queue one pending coin per type,
//          and emit registered single-cycle coin pulses one at a time.
// Ports:
//   clk, reset                        : clock (rising edge), synchronous active-high reset
//   btn_quarter, btn_nickel, btn_dime : raw bouncing coin contacts
//   sw_soda, sw_diet                  : raw drink-select switches
//   hold                              : freezes coin emission while high
//   quarter, nickel, dime             : registered one-cycle coin pulses, at most one per cycle
//   soda, diet                        : registered debounced select levels
//   overrun                           : registered one-cycle pulse when a coin is lost
module coin_front_end
  import vending_pkg::*;
#(
  parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_quarter,
  input  logic btn_nickel,
  input  logic btn_dime,
  input  logic sw_soda,
  input  logic sw_diet,
  input  logic hold,
  output logic quarter,
  output logic nickel,
  output logic dime,
  output logic soda,
  output logic diet,
  output logic overrun
);

  localparam int unsigned NUM_IN = 5;

  logic [NUM_IN-1:0]    raw_in;
  logic [NUM_IN-1:0]    stable_w;
  logic [NUM_COINS-1:0] coin_stable;
  logic [NUM_COINS-1:0] coin_prev_q;
  logic [NUM_COINS-1:0] coin_rise;
  logic [NUM_COINS-1:0] grant;
  logic [NUM_COINS-1:0] pending_q;
  logic [NUM_COINS-1:0] pending_d;
  logic [NUM_COINS-1:0] coin_q;
  logic [1:0]           sel_q;
  logic                 overrun_q;
  logic                 overrun_d;

  // Coins occupy the low indices in coin_e order; selects sit above them.
  assign raw_in = {sw_diet, sw_soda, btn_dime, btn_nickel, btn_quarter};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    debounce_sync #(
      .DB_COUNT (DB_COUNT),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_in[g]),
      .stable (stable_w[g])
    );
  end

  assign coin_stable = stable_w[NUM_COINS-1:0];
  assign coin_rise   = coin_stable & ~coin_prev_q;

  // A rise on a coin that is being emitted this cycle simply re-arms it;
  // a rise on a coin still waiting is lost and flagged.
  always_comb begin
    grant     = hold ? '0 : pick_coin(pending_q);
    pending_d = (pending_q & ~grant) | coin_rise;
    overrun_d = |(coin_rise & pending_q & ~grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coin_prev_q <= '0;
      pending_q   <= '0;
      coin_q      <= '0;
      sel_q       <= '0;
      overrun_q   <= 1'b0;
    end else begin
      coin_prev_q <= coin_stable;
      pending_q   <= pending_d;
      coin_q      <= grant;
      sel_q       <= stable_w[NUM_IN-1:NUM_COINS];
      overrun_q   <= overrun_d;
    end
  end

  assign quarter = coin_q[COIN_QUARTER];
  assign nickel  = coin_q[COIN_NICKEL];
  assign dime    = coin_q[COIN_DIME];
  assign soda    = sel_q[0];
  assign diet    = sel_q[1];
  assign overrun = overrun_q;

endmodule
